// File: rtl/mem_noc_sram_bridge.sv
// mem_noc_sram_bridge
//   Executes crossed memory requests on a single-port synchronous SRAM and
//   returns one response per request, in acceptance order, through a small
//   response FIFO with backpressure. Requests whose word index falls outside
//   the SRAM get an error response and never touch the macro.
//
// Ports
//   clk, rst                 destination-domain clock, sync active-high reset
//   req_valid/req_ready      request handshake
//   req_addr/wr/wdata/mask   byte address, direction, write data, byte enables
//   resp_valid/resp_ready    response handshake
//   resp_rdata/wr/err        read data (0 for writes/errors), echo, range error
//   sram_ce/we/addr/wdata/wmask  SRAM command, driven in the accept cycle
//   sram_rdata               SRAM read data, valid the cycle after a read
module mem_noc_sram_bridge #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_WORDS  = 1024,
  parameter int RESP_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [AW-1:0]                req_addr,
  input  logic                         req_wr,
  input  logic [DW-1:0]                req_wdata,
  input  logic [DW/8-1:0]              req_mask,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [DW-1:0]                resp_rdata,
  output logic                         resp_wr,
  output logic                         resp_err,
  output logic                         sram_ce,
  output logic                         sram_we,
  output logic [$clog2(MEM_WORDS)-1:0] sram_addr,
  output logic [DW-1:0]                sram_wdata,
  output logic [DW/8-1:0]              sram_wmask,
  input  logic [DW-1:0]                sram_rdata
);

  localparam int NB  = DW / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = AW - LSB;
  localparam int MAW = $clog2(MEM_WORDS);
  localparam int PW  = $clog2(RESP_DEPTH);
  localparam int CW  = PW + 1;

  logic [IW-1:0] word_idx;
  logic          in_range;
  logic          accept;
  logic          unused_addr_lsbs;

  logic          vld_p1;
  logic          wr_p1;
  logic          err_p1;
  logic [DW-1:0] rdata_p1;

  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          push;
  logic          pop;

  logic [DW-1:0] fifo_rdata [RESP_DEPTH];
  logic          fifo_wr    [RESP_DEPTH];
  logic          fifo_err   [RESP_DEPTH];

  assign word_idx         = req_addr[AW-1:LSB];
  assign in_range         = word_idx < IW'(MEM_WORDS);
  assign unused_addr_lsbs = ^req_addr[LSB-1:0];

  // Credit: every accepted request owns a FIFO slot from accept until pop, so
  // buffered plus in-flight can never exceed the FIFO depth. Only registered
  // state (and rst) feeds req_ready.
  assign occupancy = {1'b0, count} + (CW+1)'(vld_p1);
  assign req_ready = !rst && (occupancy < (CW+1)'(RESP_DEPTH));
  assign accept    = req_valid && req_ready;

  // ---- p0: accept cycle, SRAM command issued combinationally ----
  always_comb begin
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_wmask = '0;
    if (accept && in_range) begin
      sram_ce    = 1'b1;
      sram_we    = req_wr;
      sram_addr  = word_idx[MAW-1:0];
      sram_wdata = req_wdata;
      sram_wmask = req_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= accept;
    wr_p1  <= req_wr;
    err_p1 <= !in_range;
  end

  // ---- p1: SRAM read data returns, response entry pushed into the FIFO ----
  assign rdata_p1 = (!wr_p1 && !err_p1) ? sram_rdata : '0;
  assign push     = vld_p1;
  assign pop      = resp_valid && resp_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rdata[wptr] <= rdata_p1;
      fifo_wr[wptr]    <= wr_p1;
      fifo_err[wptr]   <= err_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      resp_fifo_no_overflow: assert (!(push && !pop && count == CW'(RESP_DEPTH)));
    end
  end

  // ---- p2: FIFO head drives the response port; data forced to 0 when empty ----
  assign resp_valid = (count != '0);
  assign resp_rdata = resp_valid ? fifo_rdata[rptr] : '0;
  assign resp_wr    = resp_valid ? fifo_wr[rptr]    : 1'b0;
  assign resp_err   = resp_valid ? fifo_err[rptr]   : 1'b0;

endmodule

// File: tb/tb_mem_noc_sram_bridge.sv
module tb_mem_noc_sram_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wr;
  logic [31:0] req_wdata;
  logic [3:0]  req_mask;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_wr;
  logic        resp_err;
  logic        sram_ce;
  logic        sram_we;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_wmask;
  logic [31:0] sram_rdata;

  mem_noc_sram_bridge #(.AW(32), .DW(32), .MEM_WORDS(1024), .RESP_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wr(req_wr), .req_wdata(req_wdata), .req_mask(req_mask),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_wr(resp_wr), .resp_err(resp_err),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_wmask(sram_wmask), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM model: word i starts as 0xC0DE0000+i, byte-masked writes, 1-cycle reads.
  logic [31:0] mem [1024];
  logic        mem_init_done = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 + i;
      mem_init_done <= 1'b1;
    end else if (sram_ce) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] q_rdata [$];
  logic        q_wr    [$];
  logic        q_err   [$];
  int          q_cyc   [$];
  always @(negedge clk) begin
    if (resp_valid && resp_ready) begin
      q_rdata.push_back(resp_rdata);
      q_wr.push_back(resp_wr);
      q_err.push_back(resp_err);
      q_cyc.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  int          acc_cyc;
  int          waited;
  logic        a_ce, a_we;
  logic [9:0]  a_addr;
  logic [31:0] a_wdata;
  logic [3:0]  a_mask;

  function automatic logic [31:0] exp_word(input int i);
    if (i == 4) return 32'hDEAD_BEEF;
    if (i == 8) return 32'hFF22_FF44;
    return 32'hC0DE_0000 + i;
  endfunction

  task automatic clear_q();
    q_rdata.delete(); q_wr.delete(); q_err.delete(); q_cyc.delete();
  endtask

  // Present one request (valid stays high on return) and capture the SRAM
  // command seen in the accept cycle.
  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] m);
    logic got;
    got = 1'b0;
    req_valid = 1'b1; req_addr = a; req_wr = w; req_wdata = d; req_mask = m;
    waited = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready) begin
        acc_cyc = cyc; a_ce = sram_ce; a_we = sram_we; a_addr = sram_addr;
        a_wdata = sram_wdata; a_mask = sram_wmask;
        got = 1'b1;
        break;
      end
      waited++;
    end
    if (!got) begin
      n_checks++;
      $display("FAIL issue_timeout addr=%h: req_ready never rose within 100 cycles", a);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_resps(input int n);
    for (int k = 0; k < 200 && q_rdata.size() < n; k++) @(negedge clk);
    n_checks++;
    if (q_rdata.size() < n)
      $display("FAIL resp_timeout: got %0d responses, required %0d", q_rdata.size(), n);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wr = 1'b0;
    req_wdata = '0; req_mask = '0; resp_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b required 0", resp_valid);
    else n_pass++;
    n_checks++;
    if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %b required 0", req_ready);
    else n_pass++;
    n_checks++;
    if ({resp_rdata, resp_wr, resp_err} !== 34'h0)
      $display("FAIL rst_resp_data: got %h/%b/%b required 0", resp_rdata, resp_wr, resp_err);
    else n_pass++;
    n_checks++;
    if (sram_ce !== 1'b0) $display("FAIL rst_sram_ce: got %b required 0", sram_ce);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL post_rst_ready: got %b required 1", req_ready);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    int acc_w, acc_r;
    clear_q();
    issue(32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF);
    acc_w = acc_cyc;
    n_checks++;
    if ({a_ce, a_we, a_addr, a_wdata, a_mask} !== {1'b1, 1'b1, 10'd4, 32'hDEAD_BEEF, 4'hF})
      $display("FAIL wr_sram_cmd: got ce=%b we=%b addr=%0d wdata=%h mask=%h required 1 1 4 deadbeef f",
               a_ce, a_we, a_addr, a_wdata, a_mask);
    else n_pass++;
    issue(32'h10, 1'b0, 32'h0, 4'h0);
    acc_r = acc_cyc;
    n_checks++;
    if ({a_ce, a_we, a_addr} !== {1'b1, 1'b0, 10'd4})
      $display("FAIL rd_sram_cmd: got ce=%b we=%b addr=%0d required 1 0 4", a_ce, a_we, a_addr);
    else n_pass++;
    idle(1);
    wait_resps(2);
    if (q_rdata.size() >= 2) begin
      n_checks++;
      if ({q_wr[0], q_err[0], q_rdata[0]} !== {1'b1, 1'b0, 32'h0})
        $display("FAIL wr_ack: got wr=%b err=%b rdata=%h required 1 0 0", q_wr[0], q_err[0], q_rdata[0]);
      else n_pass++;
      n_checks++;
      if ({q_wr[1], q_err[1], q_rdata[1]} !== {1'b0, 1'b0, 32'hDEAD_BEEF})
        $display("FAIL rd_data: got wr=%b err=%b rdata=%h required 0 0 deadbeef", q_wr[1], q_err[1], q_rdata[1]);
      else n_pass++;
      n_checks++;
      if (q_cyc[0] - acc_w !== 2) $display("FAIL wr_latency: got %0d required 2", q_cyc[0] - acc_w);
      else n_pass++;
      n_checks++;
      if (q_cyc[1] - acc_r !== 2) $display("FAIL rd_latency: got %0d required 2", q_cyc[1] - acc_r);
      else n_pass++;
    end
  endtask

  task automatic test_byte_mask();
    clear_q();
    issue(32'h20, 1'b1, 32'hFFFF_FFFF, 4'hF);
    issue(32'h20, 1'b1, 32'h1122_3344, 4'h5);
    issue(32'h20, 1'b0, 32'h0, 4'h0);
    issue(32'h20, 1'b1, 32'h0000_0000, 4'h0);
    n_checks++;
    if ({a_ce, a_we, a_mask} !== {1'b1, 1'b1, 4'h0})
      $display("FAIL mask0_sram_cmd: got ce=%b we=%b mask=%h required 1 1 0", a_ce, a_we, a_mask);
    else n_pass++;
    issue(32'h20, 1'b0, 32'h0, 4'h0);
    idle(1);
    wait_resps(5);
    if (q_rdata.size() >= 5) begin
      n_checks++;
      if (q_rdata[2] !== 32'hFF22_FF44)
        $display("FAIL byte_mask: got rdata=%h required ff22ff44", q_rdata[2]);
      else n_pass++;
      n_checks++;
      if ({q_wr[3], q_err[3], q_rdata[3]} !== {1'b1, 1'b0, 32'h0})
        $display("FAIL mask0_ack: got wr=%b err=%b rdata=%h required 1 0 0", q_wr[3], q_err[3], q_rdata[3]);
      else n_pass++;
      n_checks++;
      if (q_rdata[4] !== 32'hFF22_FF44)
        $display("FAIL mask0_noop: got rdata=%h required ff22ff44", q_rdata[4]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int stalls;
    stalls = 0;
    clear_q();
    resp_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      issue(32'(4 * i), 1'b0, 32'h0, 4'h0);
      stalls += waited;
    end
    idle(1);
    n_checks++;
    if (stalls !== 0) $display("FAIL b2b_ready: got %0d stall cycles required 0", stalls);
    else n_pass++;
    wait_resps(16);
    if (q_rdata.size() >= 16) begin
      for (int i = 0; i < 16; i++) begin
        n_checks++;
        if (q_rdata[i] !== exp_word(i) || q_cyc[i] !== q_cyc[0] + i)
          $display("FAIL b2b_resp[%0d]: got rdata=%h cyc=+%0d required %h +%0d",
                   i, q_rdata[i], q_cyc[i] - q_cyc[0], exp_word(i), i);
        else n_pass++;
      end
    end
  endtask

  task automatic test_out_of_range();
    clear_q();
    resp_ready = 1'b1;
    issue(32'h0C, 1'b0, 32'h0, 4'h0);
    issue(32'h1000, 1'b0, 32'h0, 4'h0);
    n_checks++;
    if (a_ce !== 1'b0) $display("FAIL oor_rd_ce: got %b required 0", a_ce);
    else n_pass++;
    issue(32'h1004, 1'b1, 32'hABCD_0123, 4'hF);
    n_checks++;
    if (a_ce !== 1'b0) $display("FAIL oor_wr_ce: got %b required 0", a_ce);
    else n_pass++;
    issue(32'h18, 1'b0, 32'h0, 4'h0);
    idle(1);
    wait_resps(4);
    if (q_rdata.size() >= 4) begin
      n_checks++;
      if ({q_err[0], q_rdata[0]} !== {1'b0, 32'hC0DE_0003})
        $display("FAIL oor_before: got err=%b rdata=%h required 0 c0de0003", q_err[0], q_rdata[0]);
      else n_pass++;
      n_checks++;
      if ({q_wr[1], q_err[1], q_rdata[1]} !== {1'b0, 1'b1, 32'h0})
        $display("FAIL oor_rd_resp: got wr=%b err=%b rdata=%h required 0 1 0", q_wr[1], q_err[1], q_rdata[1]);
      else n_pass++;
      n_checks++;
      if ({q_wr[2], q_err[2], q_rdata[2]} !== {1'b1, 1'b1, 32'h0})
        $display("FAIL oor_wr_resp: got wr=%b err=%b rdata=%h required 1 1 0", q_wr[2], q_err[2], q_rdata[2]);
      else n_pass++;
      n_checks++;
      if ({q_err[3], q_rdata[3]} !== {1'b0, 32'hC0DE_0006})
        $display("FAIL oor_after: got err=%b rdata=%h required 0 c0de0006", q_err[3], q_rdata[3]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int accepted;
    accepted = 0;
    clear_q();
    resp_ready = 1'b0;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h0; req_mask = '0; req_wdata = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_ready) accepted++;
      @(posedge clk); #1;
      req_addr = 32'(4 * accepted);
    end
    n_checks++;
    if (accepted !== 4) $display("FAIL bp_accept_count: got %0d required 4", accepted);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0) $display("FAIL bp_ready_low: got %b required 0", req_ready);
    else n_pass++;
    n_checks++;
    if ({resp_valid, resp_rdata} !== {1'b1, 32'hC0DE_0000})
      $display("FAIL bp_hold_a: got valid=%b rdata=%h required 1 c0de0000", resp_valid, resp_rdata);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({resp_valid, resp_rdata} !== {1'b1, 32'hC0DE_0000})
      $display("FAIL bp_hold_b: got valid=%b rdata=%h required 1 c0de0000", resp_valid, resp_rdata);
    else n_pass++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    wait_resps(4);
    issue(32'h14, 1'b0, 32'h0, 4'h0);
    idle(1);
    wait_resps(5);
    idle(4);
    n_checks++;
    if (q_rdata.size() !== 5) $display("FAIL bp_resp_count: got %0d required 5", q_rdata.size());
    else n_pass++;
    if (q_rdata.size() >= 5) begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (q_rdata[i] !== 32'hC0DE_0000 + i)
          $display("FAIL bp_drain[%0d]: got rdata=%h required %h", i, q_rdata[i], 32'hC0DE_0000 + i);
        else n_pass++;
      end
      n_checks++;
      if (q_rdata[4] !== 32'hC0DE_0005)
        $display("FAIL bp_resume: got rdata=%h required c0de0005", q_rdata[4]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midop();
    int stalls;
    stalls = 0;
    clear_q();
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(32'(4 * i), 1'b0, 32'h0, 4'h0);
      stalls += waited;
    end
    // Three responses buffered, the fourth in flight.
    rst = 1'b1;
    req_valid = 1'b0;
    n_checks++;
    if (stalls !== 0) $display("FAIL midrst_fill: got %0d stall cycles required 0", stalls);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({resp_valid, req_ready, sram_ce} !== 3'b100)
      $display("FAIL midrst_during: got valid=%b ready=%b ce=%b required 1 0 0", resp_valid, req_ready, sram_ce);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({resp_valid, req_ready, resp_rdata} !== {1'b0, 1'b1, 32'h0})
      $display("FAIL midrst_after: got valid=%b ready=%b rdata=%h required 0 1 0", resp_valid, req_ready, resp_rdata);
    else n_pass++;
    @(posedge clk); #1;
    resp_ready = 1'b1;
    idle(6);
    n_checks++;
    if (q_rdata.size() !== 0) $display("FAIL midrst_stale: got %0d responses required 0", q_rdata.size());
    else n_pass++;
    issue(32'h1C, 1'b0, 32'h0, 4'h0);
    idle(1);
    wait_resps(1);
    idle(4);
    n_checks++;
    if (q_rdata.size() !== 1 || q_rdata[0] !== 32'hC0DE_0007)
      $display("FAIL midrst_resume: got %0d responses first=%h required 1 c0de0007",
               q_rdata.size(), (q_rdata.size() > 0) ? q_rdata[0] : 32'h0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_back_to_back();
    test_out_of_range();
    test_backpressure();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_noc_sram_bridge.md
Name: mem_noc_sram_bridge

Overview:
Downstream consumer of the memory-request CDC stage: it sits in the destination clock domain, takes each crossed request over a valid/ready handshake and executes it on a single-port synchronous SRAM macro. It returns one response per request (read data, or write acknowledge) through a response FIFO with backpressure. Out-of-range addresses get an error response without touching the SRAM.

Parameters:
AW, 32, byte address width of req_addr
DW, 32, data width; DW/8 byte lanes
MEM_WORDS, 1024, SRAM depth in words; valid word index 0..MEM_WORDS-1
RESP_DEPTH, 4, response FIFO entries (power of 2, >=2)

Ports:
clk  in  1  destination-domain clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request valid (from CDC dest_req_valid)
req_ready  out  1  request accepted when req_valid&&req_ready
req_addr  in  AW  byte address; word index = req_addr[AW-1:log2(DW/8)]
req_wr  in  1  1=write, 0=read
req_wdata  in  DW  write data
req_mask  in  DW/8  byte-write enables
resp_valid  out  1  response valid
resp_ready  in  1  response consumed when resp_valid&&resp_ready
resp_rdata  out  DW  read data; 0 for writes and errors
resp_wr  out  1  echo of req_wr
resp_err  out  1  1=address out of range
sram_ce  out  1  SRAM chip enable
sram_we  out  1  SRAM write enable
sram_addr  out  log2(MEM_WORDS)  SRAM word address
sram_wdata  out  DW  SRAM write data
sram_wmask  out  DW/8  SRAM byte mask
sram_rdata  in  DW  SRAM read data, valid one cycle after a read enable

Behaviour:
- Reset (rst sampled high at posedge): FIFO empty, in-flight stage cleared. resp_valid=0, req_ready=0 for the reset cycle itself, resp_* data=0.
- Reset mid-operation: all in-flight and buffered responses are discarded. No SRAM access is issued in the reset cycle. The bridge is ready in the first cycle after rst deasserts.
- Credit rule: req_ready = !rst && (fifo_count + inflight) < RESP_DEPTH, from registers only. There is no combinational path from resp_ready or req_valid.
- Accept cycle T: if the word index is < MEM_WORDS, then in the same cycle sram_ce=1, sram_we=req_wr, sram_addr=word index, sram_wdata=req_wdata, sram_wmask=req_mask. Otherwise sram_ce=0 and the request is flagged err. The sram_* signals are 0 whenever no request is accepted.
- Stage 1 register (inflight, wr, err) is captured at the end of T. In cycle T+1 the FIFO write entry is {rdata = (!wr&&!err)?sram_rdata:0, wr, err}, written at the end of T+1.
- Latency: resp_valid is high no earlier than cycle T+2 (FIFO not bypassed). Sustained throughput is 1 request/cycle while resp_ready=1.
- Response ordering: strictly in request-acceptance order.
- FIFO: push and pop in the same cycle keep the count unchanged. Read and write pointers wrap modulo RESP_DEPTH. Overflow is impossible by the credit rule; an assertion is required.
- resp_* outputs hold stable while resp_valid && !resp_ready.
- Writes with req_mask=0 still access the SRAM (no-op) and return an ack.
- Reads that follow writes to the same address see the new data. The SRAM is accessed in order, so no hazard logic is needed.

Test Plan:
- Write 0xDEADBEEF to addr 0x10, mask 0xF, then read 0x10 with resp_ready=1 -> two responses in order: {wr=1, err=0, rdata=0}, then {wr=0, err=0, rdata=0xDEADBEEF} two cycles after the read accept.
- Byte mask: write 0xFFFFFFFF to 0x20, then 0x11223344 with mask 0x5, then read 0x20 -> rdata=0xFF22FF44.
- Back-to-back reads of addrs 0x0..0x3C (16 reqs), resp_ready=1 -> req_ready stays 1, 16 in-order responses on consecutive cycles.
- Backpressure: resp_ready=0, issue reads continuously -> exactly RESP_DEPTH=4 accepted, then req_ready=0. Raise resp_ready -> the 4 buffered responses drain, then acceptance resumes, with no loss or duplication.
- Out-of-range read at byte address 4*1024=0x1000 -> sram_ce stays 0, response {err=1, rdata=0}, and in-order position is preserved.
- Assert rst for 1 cycle with 3 responses buffered and 1 in flight -> resp_valid=0 next cycle, FIFO empty, req_ready=1 the cycle after reset deasserts, and no stale responses appear afterwards.
